// File: rtl/chan_scan_capture.sv
// Multi-channel capture registers with a valid/ready scan engine.
// A pass walks channels 0..N_CH-1, emitting each (or only dirty ones) and
// recording every accepted word in a snapshot vector.
module chan_scan_capture #(
   parameter int N_CH       = 8,
   parameter int W          = 1,
   parameter int DIRTY_ONLY = 0,
   localparam int IW        = $clog2(N_CH)
) (
   input  logic                 i_clk,
   input  logic                 i_arst,
   input  logic                 i_en,
   input  logic [N_CH-1:0]      i_ch_valid,
   input  logic [N_CH*W-1:0]    i_ch_data,
   input  logic                 i_scan_start,
   input  logic                 i_ready,
   output logic                 o_valid,
   output logic [IW-1:0]        o_ch_idx,
   output logic [W-1:0]         o_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [N_CH*W-1:0]    o_snapshot
);

   // Output stream: o_valid rises with o_ch_idx/o_data; all three hold
   // steady until the cycle where o_valid && i_ready, which is the transfer.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [W-1:0]        cap_q [N_CH];
   logic [W-1:0]        cap_d [N_CH];
   logic [N_CH-1:0]     dirty_q, dirty_d;
   logic                valid_q, valid_d;
   logic [IW-1:0]       ch_idx_q, ch_idx_d;
   logic [W-1:0]        data_q, data_d;
   logic [N_CH*W-1:0]   snap_q, snap_d;
   logic                eligible;

   assign eligible = (DIRTY_ONLY == 0) || dirty_q[idx_q];

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cap_d    = cap_q;
      dirty_d  = dirty_q;
      valid_d  = valid_q;
      ch_idx_d = ch_idx_q;
      data_d   = data_q;
      snap_d   = snap_q;

      case (state_q)
         S_IDLE: begin
            if (i_scan_start) begin
               state_d = S_SCAN;
               idx_d   = '0;
            end
         end

         S_SCAN: begin
            if (!valid_q) begin
               if (eligible) begin
                  data_d          = cap_q[idx_q];
                  ch_idx_d        = idx_q;
                  valid_d         = 1'b1;
                  dirty_d[idx_q]  = 1'b0;
               end else if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (i_ready) begin
               snap_d[int'(idx_q)*W +: W] = data_q;
               valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end

         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase

      // Capture is applied last so a same-cycle capture overrides the
      // dirty clear made when the channel is loaded for emission.
      for (int c = 0; c < N_CH; c++) begin
         if (i_en && i_ch_valid[c]) begin
            if ((DIRTY_ONLY == 0) || (i_ch_data[c*W +: W] != cap_q[c])) begin
               dirty_d[c] = 1'b1;
            end
            cap_d[c] = i_ch_data[c*W +: W];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cap_q    <= '{default: '0};
         dirty_q  <= '0;
         valid_q  <= 1'b0;
         ch_idx_q <= '0;
         data_q   <= '0;
         snap_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cap_q    <= cap_d;
         dirty_q  <= dirty_d;
         valid_q  <= valid_d;
         ch_idx_q <= ch_idx_d;
         data_q   <= data_d;
         snap_q   <= snap_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_ch_idx   = ch_idx_q;
   assign o_data     = data_q;
   assign o_busy     = (state_q != S_IDLE);
   assign o_done     = (state_q == S_DONE);
   assign o_snapshot = snap_q;

endmodule

// File: tb/tb_chan_scan_capture.sv
// Bench for chan_scan_capture: one full-scan instance and one dirty-only
// instance driven by the same inputs, with directed, table and random passes.
module tb_chan_scan_capture;

   localparam int N_CH = 8;
   localparam int W    = 4;
   localparam int IW   = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic [N_CH-1:0]      ch_valid;
   logic [N_CH*W-1:0]    ch_data;
   logic                 start;
   logic                 ready;

   logic                 v0, busy0, done0;
   logic [IW-1:0]        idx0;
   logic [W-1:0]         d0;
   logic [N_CH*W-1:0]    snap0;
   logic                 v1, busy1, done1;
   logic [IW-1:0]        idx1;
   logic [W-1:0]         d1;
   logic [N_CH*W-1:0]    snap1;

   chan_scan_capture #(.N_CH(N_CH), .W(W), .DIRTY_ONLY(0)) dut_full (
      .i_clk(clk), .i_arst(rst), .i_en(en), .i_ch_valid(ch_valid),
      .i_ch_data(ch_data), .i_scan_start(start), .i_ready(ready),
      .o_valid(v0), .o_ch_idx(idx0), .o_data(d0), .o_busy(busy0),
      .o_done(done0), .o_snapshot(snap0)
   );

   chan_scan_capture #(.N_CH(N_CH), .W(W), .DIRTY_ONLY(1)) dut_dirty (
      .i_clk(clk), .i_arst(rst), .i_en(en), .i_ch_valid(ch_valid),
      .i_ch_data(ch_data), .i_scan_start(start), .i_ready(ready),
      .o_valid(v1), .o_ch_idx(idx1), .o_data(d1), .o_busy(busy1),
      .o_done(done1), .o_snapshot(snap1)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- monitor: accepted words and done pulses ----------------
   int done0_cnt = 0;
   int done1_cnt = 0;
   logic [IW+W-1:0] act0_q[$];
   logic [IW+W-1:0] act1_q[$];
   logic [IW+W-1:0] exp0_q[$];
   logic [IW+W-1:0] exp1_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (v0 && ready) act0_q.push_back({idx0, d0});
         if (v1 && ready) act1_q.push_back({idx1, d1});
         if (done0) done0_cnt++;
         if (done1) done1_cnt++;
      end
   end

   // ---------------- reference model ----------------
   logic [W-1:0]       m_cap [N_CH];
   logic [N_CH-1:0]    m_dirty1;
   logic [N_CH*W-1:0]  m_snap0, m_snap1;

   typedef struct {
      logic [N_CH-1:0]   mask;
      logic [N_CH*W-1:0] data;
      logic [N_CH*W-1:0] exp_snap0;
      int                exp_cnt1;
      logic [N_CH*W-1:0] exp_snap1;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) m_cap[c] = '0;
      m_dirty1 = '0;
      m_snap0  = '0;
      m_snap1  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; ch_valid = '0; ch_data = '0; start = 1'b0; ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      act0_q.delete();
      act1_q.delete();
   endtask

   // A capture in dirty-only mode marks a channel only when its value changes.
   task automatic drive_capture(input logic [N_CH-1:0] mask, input logic [N_CH*W-1:0] data,
                                input logic en_v);
      en = en_v; ch_valid = mask; ch_data = data;
      if (en_v) begin
         for (int c = 0; c < N_CH; c++) begin
            if (mask[c]) begin
               if (data[c*W +: W] != m_cap[c]) m_dirty1[c] = 1'b1;
               m_cap[c] = data[c*W +: W];
            end
         end
      end
      tick();
      en = 1'b0; ch_valid = '0;
   endtask

   // Expected emissions of one pass for both instances, from the model state.
   task automatic model_pass();
      exp0_q.delete();
      exp1_q.delete();
      for (int c = 0; c < N_CH; c++) begin
         exp0_q.push_back({IW'(c), m_cap[c]});
         m_snap0[c*W +: W] = m_cap[c];
         if (m_dirty1[c]) begin
            exp1_q.push_back({IW'(c), m_cap[c]});
            m_snap1[c*W +: W] = m_cap[c];
            m_dirty1[c] = 1'b0;
         end
      end
   endtask

   task automatic run_pass(input int limit, input bit rnd_ready, input string name);
      int b0 = done0_cnt;
      int b1 = done1_cnt;
      int n  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while ((done0_cnt == b0 || done1_cnt == b1) && n < limit) begin
         if (rnd_ready) ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      ready = 1'b1;
      check({name, "_timeout"}, 64'(n < limit), 64'd1);
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n = 0;
      while ((busy0 || busy1) && n < limit) begin
         tick();
         n++;
      end
      check({name, "_idle"}, 64'(n < limit), 64'd1);
   endtask

   task automatic compare_q(input string name);
      check({name, "_len0"}, 64'(act0_q.size()), 64'(exp0_q.size()));
      check({name, "_len1"}, 64'(act1_q.size()), 64'(exp1_q.size()));
      for (int i = 0; i < act0_q.size() && i < exp0_q.size(); i++)
         check($sformatf("%s_w0_%0d", name, i), 64'(act0_q[i]), 64'(exp0_q[i]));
      for (int i = 0; i < act1_q.size() && i < exp1_q.size(); i++)
         check($sformatf("%s_w1_%0d", name, i), 64'(act1_q[i]), 64'(exp1_q[i]));
   endtask

   initial begin
      int n;
      int fv, fd;
      logic [IW+W-1:0] fw;
      logic [N_CH*W-1:0] cur, dat;
      logic [N_CH-1:0] msk;

      tbl[0] = '{8'hFF, 32'h87654321, 32'h87654321, 8, 32'h87654321};
      tbl[1] = '{8'h04, 32'h87654A21, 32'h87654A21, 1, 32'h87654A21};
      tbl[2] = '{8'h20, 32'h87654A21, 32'h87654A21, 0, 32'h87654A21};
      tbl[3] = '{8'h81, 32'h00000000, 32'h07654A20, 2, 32'h07654A20};
      tbl[4] = '{8'hFF, 32'h07654A20, 32'h07654A20, 0, 32'h07654A20};

      // ---- reset defaults and reset in the middle of a pending word ----
      rst = 1'b1; en = 1'b0; ch_valid = '0; ch_data = '0; start = 1'b0; ready = 1'b0;
      tick();
      tick();
      check("rst_out0", 64'({v0, idx0, d0, busy0, done0, snap0}), 64'd0);
      check("rst_out1", 64'({v1, idx1, d1, busy1, done1, snap1}), 64'd0);
      rst = 1'b0;
      model_reset();
      drive_capture(8'hFF, 32'h87654321, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!v0 && n < 10) begin
         tick();
         n++;
      end
      check("midscan_valid", 64'(v0), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst0", 64'({v0, idx0, d0, busy0, done0, snap0}), 64'd0);
      check("async_rst1", 64'({v1, idx1, d1, busy1, done1, snap1}), 64'd0);
      tick();
      rst = 1'b0;
      model_reset();
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("restart_ch0", 64'({v0, idx0, d0}), 64'({1'b1, 3'd0, 4'd0}));
      wait_idle(50, "restart");

      // ---- full scan timing ----
      do_reset();
      ready = 1'b1;
      drive_capture(8'hFF, 32'h87654321, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         bit exp_v;
         tick();
         exp_v = (k % 2 == 1) && (k <= 15);
         check($sformatf("full_vd_k%0d", k), 64'({v0, done0}), 64'({exp_v, k == 16}));
         if (exp_v)
            check($sformatf("full_word_k%0d", k), 64'({idx0, d0}),
                  64'({3'((k - 1) / 2), 4'((k + 1) / 2)}));
      end
      check("full_snap", 64'(snap0), 64'h87654321);
      check("full_busy_end", 64'(busy0), 64'd0);

      // ---- backpressure on ch3 with a capture while pending ----
      do_reset();
      ready = 1'b1;
      drive_capture(8'hFF, 32'h87654321, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(v0 && idx0 == 3'd3) && n < 40) begin
         tick();
         n++;
      end
      check("bp_reach_ch3", 64'(n < 40), 64'd1);
      ready = 1'b0;
      en = 1'b1; ch_valid = 8'h08; ch_data = 32'h8765F321;
      tick();
      en = 1'b0; ch_valid = '0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("bp_hold0_%0d", i), 64'({v0, idx0, d0}), 64'({1'b1, 3'd3, 4'd4}));
         check($sformatf("bp_hold1_%0d", i), 64'({v1, idx1, d1}), 64'({1'b1, 3'd3, 4'd4}));
         tick();
      end
      ready = 1'b1;
      wait_idle(50, "bp");
      check("bp_snap0", 64'(snap0), 64'h87654321);
      check("bp_snap1", 64'(snap1), 64'h87654321);
      act1_q.delete();
      run_pass(60, 1'b0, "bp_rescan");
      check("bp_dirty_len", 64'(act1_q.size()), 64'd1);
      if (act1_q.size() > 0) check("bp_dirty_word", 64'(act1_q[0]), 64'({3'd3, 4'hF}));
      check("bp_rescan_snap1", 64'(snap1), 64'h8765F321);
      check("bp_rescan_snap0", 64'(snap0), 64'h8765F321);

      // ---- dirty-only pass length ----
      do_reset();
      ready = 1'b1;
      drive_capture(8'hFF, 32'h87654321, 1'b1);
      run_pass(60, 1'b0, "dl_first");
      drive_capture(8'h24, 32'h87654A21, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      fv = -1; fd = -1; fw = '0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (v1 && fv < 0) begin
            fv = k;
            fw = {idx1, d1};
         end
         if (done1 && fd < 0) fd = k;
      end
      check("dl_first_valid_k", 64'(fv), 64'd3);
      check("dl_word", 64'(fw), 64'({3'd2, 4'hA}));
      check("dl_done_k", 64'(fd), 64'd9);
      wait_idle(50, "dl");

      // ---- capture/clear collision on ch0 ----
      do_reset();
      ready = 1'b1;
      drive_capture(8'hFF, 32'h00000003, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      en = 1'b1; ch_valid = 8'h01; ch_data = 32'h00000006;
      tick();
      en = 1'b0; ch_valid = '0;
      check("coll_old1", 64'({v1, idx1, d1}), 64'({1'b1, 3'd0, 4'd3}));
      check("coll_old0", 64'({v0, idx0, d0}), 64'({1'b1, 3'd0, 4'd3}));
      wait_idle(50, "coll");
      act1_q.delete();
      run_pass(60, 1'b0, "coll_rescan");
      check("coll_len", 64'(act1_q.size()), 64'd1);
      if (act1_q.size() > 0) check("coll_word", 64'(act1_q[0]), 64'({3'd0, 4'd6}));
      check("coll_snap1", 64'(snap1), 64'h00000006);

      // ---- start ignored while busy ----
      n = done0_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         start = done0;
         tick();
      end
      start = 1'b0;
      tick();
      check("ign_done_cnt", 64'(done0_cnt - n), 64'd1);
      check("ign_idle", 64'(busy0), 64'd0);
      wait_idle(50, "ign");

      // ---- table-driven passes ----
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_capture(tbl[i].mask, tbl[i].data, 1'b1);
         act1_q.delete();
         run_pass(60, 1'b0, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d_snap0", i), 64'(snap0), 64'(tbl[i].exp_snap0));
         check($sformatf("tbl%0d_cnt1", i), 64'(act1_q.size()), 64'(tbl[i].exp_cnt1));
         check($sformatf("tbl%0d_snap1", i), 64'(snap1), 64'(tbl[i].exp_snap1));
      end

      // ---- randomized passes against the model ----
      do_reset();
      ready = 1'b1;
      for (int r = 0; r < 25; r++) begin
         int ncap = $urandom_range(0, 3);
         for (int j = 0; j < ncap; j++) begin
            for (int c = 0; c < N_CH; c++) cur[c*W +: W] = m_cap[c];
            dat = $urandom;
            for (int c = 0; c < N_CH; c++)
               if ($urandom_range(0, 1) == 0) dat[c*W +: W] = cur[c*W +: W];
            msk = 8'($urandom);
            drive_capture(msk, dat, 1'($urandom_range(0, 3) != 0));
         end
         model_pass();
         act0_q.delete();
         act1_q.delete();
         run_pass(400, 1'b1, $sformatf("rnd%0d", r));
         compare_q($sformatf("rnd%0d", r));
         check($sformatf("rnd%0d_snap0", r), 64'(snap0), 64'(m_snap0));
         check($sformatf("rnd%0d_snap1", r), 64'(snap1), 64'(m_snap1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
